md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Multiply/divide sequencer for the 5-stage MIPS pipeline. Owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo issued from the E stage and models a multi-cycle latency with a down-counter.
- Drives the D-stage stall for any instruction that touches HI/LO while an operation is in flight.
- Sits beside the ALU in E. Its operands are the already-forwarded E-stage RS/RT values.

Parameters:
- MULT_CYCLES, 5, cycles from mult/multu issue to HI/LO update (≥1)
- DIV_CYCLES, 10, cycles from div/divu issue to HI/LO update (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  E-stage instruction valid for this unit, sampled on clk rise
- op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- a  in  32  forwarded RS value (E stage)
- b  in  32  forwarded RT value (E stage)
- md_use_D  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight (cnt != 0)
- stall_D  out  1  freeze PC/IF-ID, bubble into E
- done  out  1  one-cycle pulse, HI/LO just updated by mult/div
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (rst_n=0, async): cnt=0, busy=0, done=0, hi=0, lo=0, pending result regs=0. Effective immediately, independent of clk. It aborts any in-flight operation, and that result is discarded.
- State: IDLE (cnt==0) and BUSY (cnt!=0). busy is driven purely from cnt.
- IDLE, start with op 1–4, on clock edge:
  - compute the 64-bit result into pend_hi/pend_lo
  - load cnt = MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4)
  - hi/lo remain unchanged
- BUSY, each edge: cnt decrements. On the edge where cnt==1:
  - hi<=pend_hi, lo<=pend_lo, cnt<=0, done<=1 for exactly one cycle
  - HI/LO therefore change on the Nth edge after the issue edge, and busy is high for N cycles.
- IDLE, start with op 5 (mthi) or op 6 (mtlo): hi<=a or lo<=a on that edge. No busy, no done.
- start while BUSY: ignored, with no effect on cnt, pend or hi/lo. The stall logic guarantees this does not occur. The bench flags it as a protocol error.
- stall_D (combinational) = md_use_D & (busy | (start & op∈{1..4})). Back-to-back mult→mfhi stalls from the issue cycle onward.
- stall_D drops in the same cycle done rises. The stalled mfhi then reads the new hi/lo from D on the following edge.
- Arithmetic:
  - mult: signed 32×32→64; multu: unsigned. {hi,lo} = product.
  - div: signed. lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned. lo = quotient, hi = remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (div or divu): lo=0xFFFFFFFF, hi=a. The full latency still applies.
- Simultaneous events: reset dominates. The completing edge and a new start on the same edge cannot coincide, because the start is ignored while cnt==1 (cnt still nonzero).
- Implementation may use `*` and `/`/`%` behaviourally. Timing is fixed by the counter, not the datapath.

Test Plan:
- Mult latency: mult a=0xFFFFFFFD (-3), b=7, start 1 cycle → busy high 5 cycles; on edge 5 hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once; hi/lo unchanged on edges 1–4.
- Divu: a=100, b=7 → after 10 edges lo=14, hi=2. Signed div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. multu 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Corner division: div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. divu 5/0 → lo=0xFFFFFFFF, hi=5, still 10 cycles.
- Stall interlock: start=mult and md_use_D=1 in the same cycle → stall_D=1 that cycle and for 5 cycles, 0 in the done cycle. md_use_D=0 while busy → stall_D=0. Second start while busy → ignored, hi/lo equal the first result.
- mthi/mtlo in IDLE: mthi a=0x12345678 → hi updated on the next edge, busy=0, stall_D=0, done=0. Then mtlo a=0xCAFEBABE → lo updated, hi kept.
- Reset mid-op: issue div, deassert rst_n asynchronously mid-cycle at cnt=6 → busy/hi/lo/done=0 immediately, no later done. A new mult after release completes normally in 5 cycles.

Source files
------------

// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer beside the E-stage ALU; owns HI/LO.
//
// Ops are issued from E with already-forwarded operands. The 64-bit result
// is computed at issue into pend and only committed to HI/LO when the
// latency down-counter expires, so the visible timing depends only on
// MULT_CYCLES/DIV_CYCLES, not on the datapath.
//
// Ports:
//   clk, rst_n       clock (rising), async active-low reset
//   start, op[2:0]   E-stage issue: 1 mult, 2 multu, 3 div, 4 divu,
//                    5 mthi, 6 mtlo, 0/7 none
//   a, b [31:0]      forwarded RS / RT
//   md_use_D         D-stage instruction touches HI/LO
//   busy             operation in flight (cnt != 0)
//   stall_D          freeze PC/IF-ID, bubble into E
//   done             one-cycle pulse after HI/LO updated by mult/div
//   hi, lo [31:0]    HI/LO registers
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_D,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  state_t        state;
  logic [CW-1:0] cnt, cnt_nxt;
  md_res_t       pend, pend_nxt, hl, hl_nxt, res;
  logic          done_nxt;
  logic          is_md, is_mul;
  logic [63:0]   a_sx, b_sx;

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_md  = is_mul || (op == OP_DIV) || (op == OP_DIVU);
  assign state  = (cnt != '0) ? BUSY : IDLE;
  assign busy   = (state == BUSY);
  // Also stall in the issue cycle itself so mult->mfhi back-to-back waits.
  assign stall_D = md_use_D & (busy | (start & is_md));
  assign hi = hl.hi;
  assign lo = hl.lo;

  assign a_sx = {{32{a[31]}}, a};
  assign b_sx = {{32{b[31]}}, b};

  // Result datapath; low 64 bits of a 64x64 product of sign-extended
  // operands equal the signed 32x32 product.
  always_comb begin
    res = '0;
    case (op)
      OP_MULT:  res = a_sx * b_sx;
      OP_MULTU: res = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0)
          res = '{hi: a, lo: 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          res = '{hi: 32'd0, lo: 32'h8000_0000};   // quotient overflows, pin it
        else begin
          res.lo = $signed(a) / $signed(b);
          res.hi = $signed(a) % $signed(b);       // sign follows dividend
        end
      end
      OP_DIVU: begin
        if (b == 32'd0)
          res = '{hi: a, lo: 32'hFFFF_FFFF};
        else begin
          res.lo = a / b;
          res.hi = a % b;
        end
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    cnt_nxt  = cnt;
    pend_nxt = pend;
    hl_nxt   = hl;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_md) begin
            pend_nxt = res;
            cnt_nxt  = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          end else if (op == OP_MTHI) begin
            hl_nxt.hi = a;
          end else if (op == OP_MTLO) begin
            hl_nxt.lo = a;
          end
        end
      end
      BUSY: begin
        // start is ignored here, including when cnt==1.
        if (cnt == CW'(1)) begin
          hl_nxt   = pend;
          cnt_nxt  = '0;
          done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pend <= '0;
      hl   <= '0;
      done <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      pend <= pend_nxt;
      hl   <= hl_nxt;
      done <= done_nxt;
    end
  end
endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        md_use_D;
  logic        busy, stall_D, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .md_use_D(md_use_D), .busy(busy), .stall_D(stall_D), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Called #1 after a rising edge. Issues one op, walks the latency window
  // checking busy/stall/hold, then checks the commit and the done pulse.
  // intr: inject a second start while busy (must be ignored).
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input int n, input logic [31:0] eh, input logic [31:0] el,
                        input logic use_d, input logic intr);
    logic [31:0] oh, ol;
    oh = hi; ol = lo;
    op = o; a = av; b = bv; start = 1'b1; md_use_D = use_d;
    #1;
    chk("stall_issue", stall_D, (use_d && n > 0) ? 1 : 0);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    for (int i = 0; i < n; i++) begin
      if (intr && i == 3) begin
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd3;
      end else begin
        start = 1'b0; op = 3'd0;
      end
      #1;
      chk("busy_win", busy, 1);
      chk("done_win", done, 0);
      chk("hi_hold", hi, oh);
      chk("lo_hold", lo, ol);
      chk("stall_win", stall_D, use_d);
      @(posedge clk); #1;
    end
    start = 1'b0; op = 3'd0;
    #1;
    chk("busy_end", busy, 0);
    chk("done_end", done, (n > 0) ? 1 : 0);
    chk("stall_end", stall_D, 0);
    chk("hi_res", hi, eh);
    chk("lo_res", lo, el);
    @(posedge clk); #1;
    chk("done_once", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; md_use_D = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", stall_D, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd1, 32'hFFFF_FFFD, 32'd7,  5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 1'b0); // mult -3*7
    run_op(3'd4, 32'd100,       32'd7, 10, 32'd2,         32'd14,        1'b0, 1'b1); // divu + intruder
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0); // div -7/2
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0); // multu
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b1, 1'b0); // div overflow
    run_op(3'd4, 32'd5,         32'd0, 10, 32'd5,         32'hFFFF_FFFF, 1'b1, 1'b0); // divu by zero
    run_op(3'd5, 32'h1234_5678, 32'd0,  0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0); // mthi
    run_op(3'd6, 32'hCAFE_BABE, 32'd0,  0, 32'h1234_5678, 32'hCAFE_BABE, 1'b1, 1'b0); // mtlo

    // Reset mid-divide at cnt==6: everything clears at once, no late done.
    op = 3'd3; a = 32'd7; b = 32'd2; start = 1'b1; md_use_D = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      chk("no_late_done", done, 0);
      chk("no_late_busy", busy, 0);
      @(posedge clk); #1;
    end
    run_op(3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
